// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing source: pixel enable, x/y counters and
//            pipeline-aligned hsync/vsync/blank_n strobes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 1,
    parameter int SYNC_ACT = 0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       line_start,
    output logic       frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       c_SYNC_ON  = (SYNC_ACT != 0);

    generate
        if (c_H_TOTAL > 1024 || c_V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H/V total exceeds 1024");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY must be 0..4");
        end
    endgenerate

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               w_div_wrap;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic               w_bl_raw;
    logic               w_hs_dly;
    logic               w_vs_dly;
    logic               w_bl_dly;

    assign w_div_wrap = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_div_wrap) begin
            if (r_x == c_H_LAST) begin
                r_x <= '0;
                if (r_y == c_V_LAST) begin
                    r_y <= '0;
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign w_hs_raw = (r_x >= c_HS_FIRST) && (r_x <= c_HS_LAST);
    assign w_vs_raw = (r_y >= c_VS_FIRST) && (r_y <= c_VS_LAST);
    assign w_bl_raw = (r_x < c_H_ACT) && (r_y < c_V_ACT);

    // Delay stages hold active-high flags, so the cleared state is "inactive".
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign w_hs_dly = w_hs_raw;
            assign w_vs_dly = w_vs_raw;
            assign w_bl_dly = w_bl_raw;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] r_hs_pipe;
            logic [PIPE_DLY-1:0] r_vs_pipe;
            logic [PIPE_DLY-1:0] r_bl_pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hs_pipe <= '0;
                    r_vs_pipe <= '0;
                    r_bl_pipe <= '0;
                end else if (w_div_wrap) begin
                    r_hs_pipe <= (r_hs_pipe << 1) | PIPE_DLY'(w_hs_raw);
                    r_vs_pipe <= (r_vs_pipe << 1) | PIPE_DLY'(w_vs_raw);
                    r_bl_pipe <= (r_bl_pipe << 1) | PIPE_DLY'(w_bl_raw);
                end
            end

            assign w_hs_dly = r_hs_pipe[PIPE_DLY-1];
            assign w_vs_dly = r_vs_pipe[PIPE_DLY-1];
            assign w_bl_dly = r_bl_pipe[PIPE_DLY-1];
        end
    endgenerate

    assign pix_en      = w_div_wrap && !rst;
    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = w_hs_dly ? c_SYNC_ON : ~c_SYNC_ON;
    assign vsync       = w_vs_dly ? c_SYNC_ON : ~c_SYNC_ON;
    // Gated so an undelayed decode of (0,0) cannot show a visible pixel in reset.
    assign blank_n     = w_bl_dly && !rst;
    assign line_start  = pix_en && (r_x == '0);
    assign frame_start = line_start && (r_y == '0);

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the VGA output path. Generates the pixel-rate enable, horizontal/vertical counters (exported as the `x`/`y` coordinates consumed by the pixel/character generator), and the `hsync`/`vsync`/`blank_n` strobes for the DAC/connector. The sync and blank outputs are delayed by a programmable number of pixels so they stay aligned with the registered latency of the downstream pixel generator.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `CLK_DIV`, 2: clk cycles per pixel (≥1)
- `PIPE_DLY`, 1: pixel delay of hsync/vsync/blank_n relative to x/y (0..4)
- `SYNC_ACT`, 0: active level of hsync/vsync (0 = active-low)

- `clk` in 1: system clock; single clock domain
- `rst` in 1: asynchronous, active-high reset
- `pix_en` out 1: one-clk pixel strobe
- `x` out 10: horizontal counter, 0..H_TOTAL-1
- `y` out 10: vertical counter, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync, level per SYNC_ACT
- `vsync` out 1: vertical sync, level per SYNC_ACT
- `blank_n` out 1: 1 = visible pixel
- `line_start` out 1: one-clk pulse at x=0
- `frame_start` out 1: one-clk pulse at x=0, y=0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be ≤1024; elaboration error otherwise.
- Divider: `div_cnt` counts 0..CLK_DIV-1, wraps. `pix_en` = (div_cnt == CLK_DIV-1) and not `rst`. CLK_DIV=1 → `pix_en` constantly 1 outside reset.
- Counters: on a clk edge with `pix_en`=1, `x` increments; `x`=H_TOTAL-1 wraps to 0 and `y` increments; `y`=V_TOTAL-1 with `x`=H_TOTAL-1 wraps both to 0. Counters hold when `pix_en`=0.
- Raw decode from current x/y: hs_raw = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); vs_raw = y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491); bl_raw = (x<H_ACTIVE)&&(y<V_ACTIVE).
- Delay line: PIPE_DLY-stage shift register of {hs_raw, vs_raw, bl_raw}, advancing only on `pix_en`. PIPE_DLY=0 → outputs are direct decode of current x/y.
- `hsync` = SYNC_ACT when delayed hs active, else ~SYNC_ACT; `vsync` likewise; `blank_n` = delayed bl.
- `line_start` = `pix_en` && x==0; `frame_start` = `pix_en` && x==0 && y==0. Not delayed by PIPE_DLY.

## Timing
- Reset (async assert, any time incl. mid-frame): div_cnt=0, x=0, y=0, `pix_en`=0, `line_start`=0, `frame_start`=0, `hsync`=`vsync`=~SYNC_ACT, `blank_n`=0, all delay stages cleared to inactive (hs/vs inactive, bl=0).
- After `rst` deasserts, first `pix_en` in clk cycle CLK_DIV (counting the first post-reset edge as 1); that cycle also shows `line_start`=`frame_start`=1 with x=y=0.
- Pixel period = CLK_DIV clks; line = H_TOTAL·CLK_DIV clks (1600); frame = V_TOTAL·H_TOTAL·CLK_DIV clks (840000).
- Sync/blank transitions occur only on clk edges where `pix_en`=1; latency from x/y value to corresponding sync/blank = PIPE_DLY pixels.
- First PIPE_DLY pixels after reset drive the reset (inactive) delay-stage contents; no spurious sync pulse.
- x/y never exceed H_TOTAL-1 / V_TOTAL-1.

## Test plan
- Reset: hold `rst` 5 clks, check all outputs at reset values; release, check `pix_en` first high in cycle 2 then every 2 clks, with `frame_start`=1 at x=0,y=0.
- Line timing, PIPE_DLY=0: `hsync` low exactly while x=656..751 (96 pixels), `blank_n`=1 for x=0..639 on y<480, 0 for all x on y=480..524.
- Delay, PIPE_DLY=1: `hsync` falls on the pixel after x=656 and rises on the pixel after x=752; `blank_n` falls on the pixel after x=640.
- Wrap: x 799→0 increments y; at (799,524)→(0,0) `frame_start` pulses once; measure 840000 clks between `frame_start` pulses; `vsync` low for exactly 2 lines (y=490..491).
- Mid-frame reset: assert `rst` asynchronously at x=700 (hsync low), y=300: `hsync` returns high and x/y=0 without waiting for `clk`; restart matches the reset scenario.
- CLK_DIV=1, SYNC_ACT=1: `pix_en` continuously 1 after reset, line = 800 clks, `hsync` high (active) for x=656..751.
